// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive from a single PWM level, with independent
// rising/falling dead bands, latched fault shutdown and a swallowed-pulse counter.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_OFF      | both gates low, waiting for enable
// S_LO_ON    | low-side gate on
// S_DT_TO_HI | dead band before the high-side gate turns on
// S_HI_ON    | high-side gate on
// S_DT_TO_LO | dead band before the low-side gate turns on
// S_FAULT    | both gates low, latched until cleared with fault released
module pwm_deadtime #(
    parameter int DT_WIDTH = 8,
    parameter int SW_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic                out_hi_o,
    output logic                out_lo_o,
    output logic                busy_o,
    output logic                fault_latched_o,
    output logic [SW_WIDTH-1:0] swallow_cnt_o
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_LO_ON    = 3'd1,
        S_DT_TO_HI = 3'd2,
        S_HI_ON    = 3'd3,
        S_DT_TO_LO = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] sw_q, sw_d;
    logic                sw_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_inc  = 1'b0;
        if (fault_i) begin
            state_d = S_FAULT;
            cnt_d   = '0;
        end else if (state_q == S_FAULT) begin
            if (fault_clr_i) begin
                state_d = S_OFF;
            end
        end else if (!en_i) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (in_i) begin
                        state_d = (dt_rise_i == '0) ? S_HI_ON : S_DT_TO_HI;
                        cnt_d   = dt_rise_i;
                    end else begin
                        state_d = (dt_fall_i == '0) ? S_LO_ON : S_DT_TO_LO;
                        cnt_d   = dt_fall_i;
                    end
                end
                S_LO_ON: begin
                    if (in_i) begin
                        state_d = (dt_rise_i == '0) ? S_HI_ON : S_DT_TO_HI;
                        cnt_d   = dt_rise_i;
                    end
                end
                S_HI_ON: begin
                    if (!in_i) begin
                        state_d = (dt_fall_i == '0) ? S_LO_ON : S_DT_TO_LO;
                        cnt_d   = dt_fall_i;
                    end
                end
                // The counter is only loaded with non-zero values and stops at 1,
                // so it can never wrap.
                S_DT_TO_HI: begin
                    if (!in_i) begin
                        state_d = S_LO_ON;
                        cnt_d   = '0;
                        sw_inc  = 1'b1;
                    end else if (cnt_q <= DT_WIDTH'(1)) begin
                        state_d = S_HI_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - DT_WIDTH'(1);
                    end
                end
                S_DT_TO_LO: begin
                    if (in_i) begin
                        state_d = S_HI_ON;
                        cnt_d   = '0;
                        sw_inc  = 1'b1;
                    end else if (cnt_q <= DT_WIDTH'(1)) begin
                        state_d = S_LO_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sw_d = sw_q;
        if (sw_inc && (sw_q != '1)) begin
            sw_d = sw_q + SW_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

    // Gate drives depend on the state register alone, so overlap is impossible.
    assign out_hi_o        = (state_q == S_HI_ON);
    assign out_lo_o        = (state_q == S_LO_ON);
    assign busy_o          = (state_q == S_DT_TO_HI) || (state_q == S_DT_TO_LO);
    assign fault_latched_o = (state_q == S_FAULT);
    assign swallow_cnt_o   = sw_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: a driver queues hand-derived expected outputs
// per applied cycle and a monitor pops and compares them after each clock edge.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_s = 1'b0;
    logic       en = 1'b0;
    logic [7:0] dr = 8'd0;
    logic [7:0] df = 8'd0;
    logic       fault = 1'b0;
    logic       fclr = 1'b0;
    logic       out_hi, out_lo, busy, flt;
    logic [7:0] swc;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [11:0] exp;
        logic        sw_chk;
        string       nm;
    } exp_t;

    exp_t q[$];

    localparam logic [3:0] H = 4'b1000;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] B = 4'b0010;
    localparam logic [3:0] F = 4'b0001;
    localparam logic [3:0] Z = 4'b0000;

    pwm_deadtime #(.DT_WIDTH(8), .SW_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_i           (in_s),
        .en_i           (en),
        .dt_rise_i      (dr),
        .dt_fall_i      (df),
        .fault_i        (fault),
        .fault_clr_i    (fclr),
        .out_hi_o       (out_hi),
        .out_lo_o       (out_lo),
        .busy_o         (busy),
        .fault_latched_o(flt),
        .swallow_cnt_o  (swc)
    );

    always #5 clk = ~clk;

    // Drive at the current negedge, queue what must be seen after the next posedge.
    task automatic step(input logic i, input logic [3:0] e, input int sw, input string nm);
        exp_t x;
        in_s     = i;
        x.exp    = {e, (sw < 0) ? 8'h00 : 8'(sw)};
        x.sw_chk = (sw >= 0);
        x.nm     = nm;
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [11:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x   = q.pop_front();
                act = {out_hi, out_lo, busy, flt, swc};
                applied++;
                if ((act[11:8] != x.exp[11:8]) || (x.sw_chk && (act[7:0] != x.exp[7:0]))) begin
                    miscompares++;
                    $display("FAIL %s: got hi/lo/busy/flt=%b sw=%0d, want %b sw=%0d%s",
                             x.nm, act[11:8], act[7:0], x.exp[11:8], x.exp[7:0],
                             x.sw_chk ? "" : " (sw unchecked)");
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_hi === 1'b1 && out_lo === 1'b1) begin
            miscompares++;
            $display("FAIL overlap: out_hi=1 out_lo=1 at %0t, want never both 1", $time);
        end
    end

    initial begin : stim
        int sw_exp;
        @(negedge clk);

        // reset and startup through a falling dead band
        rst = 1'b1; en = 1'b0;
        step(0, Z, 0, "reset0");
        step(0, Z, 0, "reset1");
        rst = 1'b0; en = 1'b1; dr = 8'd2; df = 8'd3;
        for (int j = 0; j < 3; j++) step(0, B, 0, "startup_band");
        step(0, L, 0, "startup_lo");

        // steady PWM: 8 cycles high, 9 low (top=16, comp=8)
        df = 8'd4;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 8; j++) step(1, (j < 2) ? B : H, 0, "pwm_rise");
            for (int j = 0; j < 9; j++) step(0, (j < 4) ? B : L, 0, "pwm_fall");
        end

        // short pulses swallowed by a 5-cycle rising band, counter saturates
        dr = 8'd5;
        for (int k = 1; k <= 300; k++) begin
            for (int j = 0; j < 3; j++) step(1, B, -1, "short_band");
            sw_exp = (k > 255) ? 255 : k;
            step(0, L, sw_exp, "short_swallow");
        end

        // zero dead time: direct swap, never busy
        dr = 8'd0; df = 8'd0;
        for (int j = 0; j < 3; j++) begin
            step(1, H, 255, "zero_dt_hi");
            step(0, L, 255, "zero_dt_lo");
        end
        step(1, H, 255, "zero_dt_hi_end");

        // fault latch from HI_ON
        fault = 1'b1;
        step(1, F, 255, "fault_enter");
        fault = 1'b0;
        step(0, F, 255, "fault_hold0");
        step(1, F, 255, "fault_hold1");
        step(0, F, 255, "fault_hold2");
        fault = 1'b1; fclr = 1'b1;
        step(1, F, 255, "fault_clr_blocked");
        fault = 1'b0; dr = 8'd3;
        step(1, Z, 255, "fault_clr_off");
        fclr = 1'b0;
        for (int j = 0; j < 3; j++) step(1, B, 255, "post_fault_band");
        step(1, H, 255, "post_fault_hi");

        // dt_rise change mid-band only affects the next band
        df = 8'd2; dr = 8'd6;
        step(0, B, 255, "mid_fall0");
        step(0, B, 255, "mid_fall1");
        step(0, L, 255, "mid_lo");
        for (int j = 0; j < 3; j++) step(1, B, 255, "mid_band_a");
        dr = 8'd1;
        for (int j = 0; j < 3; j++) step(1, B, 255, "mid_band_b");
        step(1, H, 255, "mid_hi");
        step(0, B, 255, "next_fall0");
        step(0, B, 255, "next_fall1");
        step(0, L, 255, "next_lo");
        step(1, B, 255, "short_rise_band");
        step(1, H, 255, "short_rise_hi");

        // en dropped mid-band, then re-enabled through a band
        step(0, B, 255, "en_band");
        en = 1'b0;
        step(0, Z, 255, "en_off");
        en = 1'b1;
        step(0, B, 255, "reen_band0");
        step(0, B, 255, "reen_band1");
        step(0, L, 255, "reen_lo");

        // reset mid-band clears the swallow counter
        dr = 8'd5;
        step(1, B, 255, "rst_band");
        rst = 1'b1;
        step(1, Z, 0, "rst_mid");
        rst = 1'b0;
        for (int j = 0; j < 5; j++) step(1, B, 0, "rst_rebar");
        step(1, H, 0, "rst_hi");

        // maximum dead time
        step(0, B, 0, "max_pre0");
        step(0, B, 0, "max_pre1");
        step(0, L, 0, "max_pre_lo");
        dr = 8'd255;
        for (int j = 0; j < 255; j++) step(1, B, 0, "max_band");
        step(1, H, 0, "max_hi");

        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
